// File: rtl/collision_detector_pkg.sv
// Shared data types for the obstacle pipeline: obstacle slot layout,
// hitbox geometry defaults and the collision scanner state encoding.
package collision_detector_pkg;

    localparam int NUM_OBSTACLES        = 10;
    localparam int OBSTACLE_WIDTH       = 32;
    localparam int PLAYER_X_DEFAULT     = 128;
    localparam int PLAYER_WIDTH_DEFAULT = 32;

    typedef struct packed {
        logic        active;
        logic [1:0]  lane;
        logic [10:0] position;
        logic [1:0]  sprite_type;
    } obstacle;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2,
        DEAD   = 2'd3
    } collision_state_t;

endpackage

// File: rtl/collision_detector_hitbox_check.sv
// Combinational overlap test of one obstacle slot against the player hitbox.
// Compares run at 12 bits so the 11-bit position can never wrap.
module hitbox_check
    import collision_detector_pkg::*;
#(
    parameter int PLAYER_X     = PLAYER_X_DEFAULT,
    parameter int PLAYER_WIDTH = PLAYER_WIDTH_DEFAULT
) (
    input  obstacle    obs,
    input  logic [1:0] lane,
    input  logic       jump,
    output logic       hit
);

    localparam logic [11:0] X_LO = 12'(PLAYER_X);
    localparam logic [11:0] X_HI = 12'(PLAYER_X + PLAYER_WIDTH + OBSTACLE_WIDTH);

    logic [11:0] pos_ext;
    logic        in_range;
    logic        lane_match;
    logic        jumped_over;
    logic        unused_sprite_lsb;

    assign pos_ext     = {1'b0, obs.position};
    assign in_range    = (pos_ext > X_LO) && (pos_ext < X_HI);
    assign lane_match  = (obs.lane == lane);
    // Only tall sprites (type 2-3) catch an airborne player.
    assign jumped_over = jump && !obs.sprite_type[1];
    assign hit         = obs.active && lane_match && in_range && !jumped_over;

    assign unused_sprite_lsb = obs.sprite_type[0];

endmodule

// File: rtl/collision_detector.sv
// Per-frame sequential scan of the obstacle slots against the player hitbox,
// with sticky game_over. Optional post-reset invulnerability: COLLISION_INVULN_EN.
//
// state  | meaning
// IDLE   | waiting for frame_trigger
// SCAN   | one slot per cycle, idx 0..9
// REPORT | scan_done (and collision_out) visible for one cycle
// DEAD   | hit reported; frozen until rst_in or game_reset
module collision_detector
    import collision_detector_pkg::*;
#(
    parameter int PLAYER_X      = PLAYER_X_DEFAULT,
    parameter int PLAYER_WIDTH  = PLAYER_WIDTH_DEFAULT,
    parameter int INVULN_FRAMES = 60
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         game_reset,
    input  logic                         frame_trigger,
    input  obstacle [NUM_OBSTACLES-1:0]  obstacles_in,
    input  logic [1:0]                   player_lane,
    input  logic                         player_jump,
    output logic                         collision_out,
    output logic [3:0]                   hit_index,
    output logic [1:0]                   hit_sprite,
    output logic                         scan_done,
    output logic                         game_over,
    output logic                         frame_overrun
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_OBSTACLES - 1);

    collision_state_t state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [1:0] lane_q, lane_d;
    logic       jump_q, jump_d;
    logic       hit_found_q, hit_found_d;
    logic [3:0] scan_idx_q, scan_idx_d;
    logic [1:0] scan_spr_q, scan_spr_d;
    logic       collision_q, collision_d;
    logic       scan_done_q, scan_done_d;
    logic       game_over_q, game_over_d;
    logic       overrun_q, overrun_d;
    logic [3:0] hit_index_q, hit_index_d;
    logic [1:0] hit_sprite_q, hit_sprite_d;

    obstacle    obs_sel;
    logic       hit;
    logic       scan_hit;
    logic       suppress;

`ifdef COLLISION_INVULN_EN
    localparam int INV_W = (INVULN_FRAMES < 2) ? 1 : $clog2(INVULN_FRAMES + 1);
    localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INVULN_FRAMES);

    logic [INV_W-1:0] invuln_cnt_q, invuln_cnt_d;

    assign suppress = (invuln_cnt_q != '0);
`else
    logic [31:0] unused_invuln_frames;

    assign unused_invuln_frames = 32'(INVULN_FRAMES);
    assign suppress             = 1'b0;
`endif

    always_comb begin
        obs_sel = '0;
        for (int i = 0; i < NUM_OBSTACLES; i++) begin
            if (idx_q == 4'(i)) begin
                obs_sel = obstacles_in[i];
            end
        end
    end

    hitbox_check #(
        .PLAYER_X     (PLAYER_X),
        .PLAYER_WIDTH (PLAYER_WIDTH)
    ) u_hitbox_check (
        .obs  (obs_sel),
        .lane (lane_q),
        .jump (jump_q),
        .hit  (hit)
    );

    assign scan_hit = hit_found_q || hit;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        lane_d       = lane_q;
        jump_d       = jump_q;
        hit_found_d  = hit_found_q;
        scan_idx_d   = scan_idx_q;
        scan_spr_d   = scan_spr_q;
        collision_d  = 1'b0;
        scan_done_d  = 1'b0;
        game_over_d  = game_over_q;
        overrun_d    = overrun_q;
        hit_index_d  = hit_index_q;
        hit_sprite_d = hit_sprite_q;
`ifdef COLLISION_INVULN_EN
        invuln_cnt_d = invuln_cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (frame_trigger) begin
                    lane_d      = player_lane;
                    jump_d      = player_jump;
                    idx_d       = '0;
                    hit_found_d = 1'b0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (frame_trigger) begin
                    overrun_d = 1'b1;
                end
                if (hit && !hit_found_q) begin
                    hit_found_d = 1'b1;
                    scan_idx_d  = idx_q;
                    scan_spr_d  = obs_sel.sprite_type;
                end
                // Outputs are registered, so the report is loaded on the
                // last scan cycle to be visible during REPORT.
                if (idx_q == LAST_IDX) begin
                    state_d     = REPORT;
                    scan_done_d = 1'b1;
                    if (scan_hit && !suppress) begin
                        collision_d  = 1'b1;
                        game_over_d  = 1'b1;
                        hit_index_d  = hit_found_q ? scan_idx_q : idx_q;
                        hit_sprite_d = hit_found_q ? scan_spr_q : obs_sel.sprite_type;
                    end
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            REPORT: begin
                if (frame_trigger) begin
                    overrun_d = 1'b1;
                end
`ifdef COLLISION_INVULN_EN
                if (invuln_cnt_q != '0) begin
                    invuln_cnt_d = invuln_cnt_q - 1'b1;
                end
`endif
                state_d = collision_q ? DEAD : IDLE;
            end
            DEAD: begin
                state_d = DEAD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (game_reset) begin
            state_d      = IDLE;
            idx_d        = '0;
            lane_d       = '0;
            jump_d       = 1'b0;
            hit_found_d  = 1'b0;
            scan_idx_d   = '0;
            scan_spr_d   = '0;
            collision_d  = 1'b0;
            scan_done_d  = 1'b0;
            game_over_d  = 1'b0;
            overrun_d    = 1'b0;
            hit_index_d  = 4'hF;
            hit_sprite_d = '0;
`ifdef COLLISION_INVULN_EN
            invuln_cnt_d = INV_LOAD;
`endif
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            lane_q       <= '0;
            jump_q       <= 1'b0;
            hit_found_q  <= 1'b0;
            scan_idx_q   <= '0;
            scan_spr_q   <= '0;
            collision_q  <= 1'b0;
            scan_done_q  <= 1'b0;
            game_over_q  <= 1'b0;
            overrun_q    <= 1'b0;
            hit_index_q  <= 4'hF;
            hit_sprite_q <= '0;
`ifdef COLLISION_INVULN_EN
            invuln_cnt_q <= INV_LOAD;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            lane_q       <= lane_d;
            jump_q       <= jump_d;
            hit_found_q  <= hit_found_d;
            scan_idx_q   <= scan_idx_d;
            scan_spr_q   <= scan_spr_d;
            collision_q  <= collision_d;
            scan_done_q  <= scan_done_d;
            game_over_q  <= game_over_d;
            overrun_q    <= overrun_d;
            hit_index_q  <= hit_index_d;
            hit_sprite_q <= hit_sprite_d;
`ifdef COLLISION_INVULN_EN
            invuln_cnt_q <= invuln_cnt_d;
`endif
        end
    end

    assign collision_out = collision_q;
    assign scan_done     = scan_done_q;
    assign game_over     = game_over_q;
    assign frame_overrun = overrun_q;
    assign hit_index     = hit_index_q;
    assign hit_sprite    = hit_sprite_q;

endmodule

// File: doc/collision_detector.md
# collision_detector

Downstream consumer of the obstacle generator's `obstacles_out` array and player position pass-through. Once per frame it snapshots the player lane and jump state, then sequentially scans all ten obstacle slots, one per cycle, for overlap with the player hitbox. It reports the first colliding slot and latches a sticky `game_over` that the top-level game FSM uses to freeze the run, until `game_reset`.

## Interface
Parameters:
- `PLAYER_X`, 128: left edge of the player hitbox, in screen pixels.
- `PLAYER_WIDTH`, 32: hitbox width in pixels.
- `INVULN_FRAMES`, 60: number of post-reset frames with collisions suppressed. Used only when `COLLISION_INVULN_EN` is defined.

Ports:
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  asynchronous, active-low reset.
- `game_reset`  in  1  synchronous, active-high; same effect as reset.
- `frame_trigger`  in  1  one-cycle pulse per frame.
- `obstacles_in`  in  obstacle [9:0]  from the generator; each entry has `active`, `lane[1:0]`, `position[10:0]`, `sprite_type[1:0]`.
- `player_lane`  in  2  current lane.
- `player_jump`  in  1  player airborne.
- `collision_out`  out  1  one-cycle pulse when this frame's scan found a hit.
- `hit_index`  out  4  slot of the first hit. Held until the next hit; 4'hF after reset.
- `hit_sprite`  out  2  sprite_type of that slot.
- `scan_done`  out  1  one-cycle pulse at the end of every scan.
- `game_over`  out  1  sticky collision flag.
- `frame_overrun`  out  1  sticky; set when `frame_trigger` arrives during a scan.

## Operation
- States are IDLE, SCAN, REPORT and DEAD.
- **IDLE**
  - On `frame_trigger`, latch `player_lane` and `player_jump`, clear `idx` and `hit_found`, and go to SCAN.
- **SCAN**
  - Evaluate `obstacles_in[idx]` live (not snapshotted). The generator updates at most once per frame, so live values are consistent for the scan.
  - Hit when all of the following hold:
    - `active` is 1;
    - `lane` equals the latched lane;
    - `position > PLAYER_X`;
    - `position < PLAYER_X + PLAYER_WIDTH + OBSTACLE_WIDTH`;
    - not (latched jump and `sprite_type[1]` == 0). Types 0–1 are low and jumpable; types 2–3 are tall and always collide.
  - All compares are done at 12 bits, zero-extended, so no underflow or wrap can occur.
  - The first hit (lowest idx) sets `hit_found` and captures the index and sprite. Later hits in the same scan are ignored.
  - After idx 9, go to REPORT.
- **REPORT** (one cycle)
  - Pulse `scan_done`.
  - If `hit_found`: pulse `collision_out`, drive `hit_index` and `hit_sprite`, set `game_over`, and go to DEAD.
  - Otherwise go to IDLE.
- **DEAD**
  - Ignore `frame_trigger`.
  - Outputs hold, except that pulses stay 0.
  - Leave only via reset or `game_reset`.
- A `frame_trigger` while in SCAN or REPORT is dropped and sets `frame_overrun`. The current scan is not restarted.
- A `frame_trigger` in the same cycle as `game_reset` is ignored: reset wins.

## Timing
- Reset values (both resets): state IDLE, `collision_out` 0, `scan_done` 0, `game_over` 0, `frame_overrun` 0, `hit_index` 4'hF, `hit_sprite` 0.
- With `frame_trigger` high in cycle t, slots 0..9 are evaluated in cycles t+1..t+10.
- `scan_done` and, if a hit was found, `collision_out` are high in cycle t+11 only. `game_over` rises in t+11 and stays high.
- Latency is fixed at 11 cycles regardless of hits; there is no early exit.
- The minimum `frame_trigger` spacing without overrun is 12 cycles.
- Reset in the middle of a scan aborts it immediately. No `scan_done` pulse is produced for the aborted scan.

## Configuration
- **`COLLISION_INVULN_EN` defined:**
  - A frame counter loads `INVULN_FRAMES` on reset or `game_reset`.
  - The counter decrements at each REPORT while nonzero.
  - While the counter is nonzero, hits are computed but not reported: no `collision_out`, no `game_over`, and the FSM returns to IDLE.
  - `scan_done` still pulses.
- **Undefined:** no counter; hits are always reported.

## Structure
- The `obstacle` struct and `OBSTACLE_WIDTH` live in the shared data package, used together with the generator.
- The new constants `PLAYER_X_DEFAULT` and `PLAYER_WIDTH_DEFAULT` also go in the shared data package.
- State enum `collision_state_t` also goes in the shared data package.
- One sub-module, `hitbox_check`: combinational, taking one obstacle plus the latched lane and jump, and outputting `hit`. It is instanced once and fed by an `idx` mux.

## Test plan
- **Basic hit.** Slot 3 is active, lane 1, position `PLAYER_X+1`, sprite 2; player in lane 1, not jumping; trigger. Expect `collision_out` at t+11, `hit_index` = 3, `hit_sprite` = 2, `game_over` = 1.
- **Jump clears low obstacle.** Same as the basic hit but sprite 0 and `player_jump` = 1. Expect `scan_done` at t+11, no `collision_out`, `game_over` = 0. Repeat with sprite 3: expect a hit.
- **Boundaries.**
  - position = `PLAYER_X`: no hit.
  - position = `PLAYER_X+PLAYER_WIDTH+OBSTACLE_WIDTH-1`: hit.
  - position = `PLAYER_X+PLAYER_WIDTH+OBSTACLE_WIDTH`: no hit.
  - position = 11'h7FF and position = 0: no hit, no wrap.
- **Priority and lane mismatch.**
  - Slots 2 and 7 both overlap in the player lane. Expect `hit_index` = 2.
  - All 10 slots overlap but are in lane 0, player in lane 2: no hit.
- **Overrun and reset.**
  - Second trigger at t+5: `frame_overrun` = 1, first scan completes at t+11.
  - `rst_in` low at t+6: all outputs reset immediately, no `scan_done`.
  - `game_reset` in DEAD: return to IDLE, `game_over` = 0.
- **Invulnerability** (`COLLISION_INVULN_EN`, `INVULN_FRAMES` = 2). An overlapping obstacle is held for 3 frames. Expect no `collision_out` on frames 1–2 and `collision_out` on frame 3.
